// File: rtl/packet_add_arbiter.sv
// packet_add_arbiter
// Two-source, packet-granular round-robin arbiter in front of the packet-add
// datapath. One source owns the output for a whole packet, and its per-packet
// config word is latched at grant time and held until the next grant.

module packet_add_arbiter #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     s0_tdata,
  input  logic              s0_tvalid,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic [2*DW-1:0]   s0_config,
  input  logic [DW-1:0]     s1_tdata,
  input  logic              s1_tvalid,
  input  logic              s1_tlast,
  output logic              s1_tready,
  input  logic [2*DW-1:0]   s1_config,
  output logic [DW-1:0]     m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [2*DW-1:0]   config_packet,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [CW-1:0]     pkt_cnt0,
  output logic [CW-1:0]     pkt_cnt1
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t state;
  state_t state_next;

  // 1 means source 1 was served most recently; reset leaves it at 1 so that
  // source 0 wins the very first tie.
  logic last_served;

  logic any_valid;
  logic pick_s1;
  logic src_tvalid;
  logic src_tlast;
  logic grant_start;
  logic pkt_done;

  assign any_valid   = s0_tvalid | s1_tvalid;
  assign pick_s1     = s1_tvalid & (~s0_tvalid | ~last_served);
  assign src_tvalid  = grant[1] ? s1_tvalid : s0_tvalid;
  assign src_tlast   = grant[1] ? s1_tlast  : s0_tlast;
  assign grant_start = (state == IDLE) & any_valid;
  assign pkt_done    = (state == STREAM) & src_tvalid & src_tlast & m_tready;
  assign busy        = (state == STREAM);

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the combinational pass-through from the owner.
  always_comb begin
    state_next = state;
    m_tdata    = '0;
    m_tvalid   = 1'b0;
    m_tlast    = 1'b0;
    s0_tready  = 1'b0;
    s1_tready  = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        m_tdata   = grant[1] ? s1_tdata : s0_tdata;
        m_tvalid  = src_tvalid;
        m_tlast   = src_tlast;
        s0_tready = grant[0] & m_tready;
        s1_tready = grant[1] & m_tready;
        if (pkt_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Grant, config latch, round-robin pointer and completed-packet counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant         <= 2'b00;
      config_packet <= '0;
      last_served   <= 1'b1;
      pkt_cnt0      <= '0;
      pkt_cnt1      <= '0;
    end else if (grant_start) begin
      grant         <= pick_s1 ? 2'b10 : 2'b01;
      config_packet <= pick_s1 ? s1_config : s0_config;
    end else if (pkt_done) begin
      grant       <= 2'b00;
      last_served <= grant[1];
      if (grant[1]) begin
        pkt_cnt1 <= pkt_cnt1 + CNT_ONE;
      end else begin
        pkt_cnt0 <= pkt_cnt0 + CNT_ONE;
      end
    end
  end

endmodule
